// File: rtl/gpio_input_conditioner.sv
// Conditions raw push-buttons and slide switches for the GPIO peripheral: two-flop
// synchroniser, per-bit debounce, press pulses, sticky press flags and a switch-change pulse.
module gpio_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] button_raw,
    input  logic [9:0] switch_raw,
    input  logic [2:0] clear_press,
    output logic [2:0] button,
    output logic [9:0] switch,
    output logic [2:0] button_press,
    output logic [2:0] press_latch,
    output logic       switch_changed
);

    localparam int unsigned NumBtn  = 3;
    localparam int unsigned NumSw   = 10;
    localparam int unsigned NumBits = NumBtn + NumSw;

    // Buttons are active-low, so their idle (released) level is 1.
    localparam logic [NumBits-1:0]   IdleLevel = {{NumSw{1'b0}}, {NumBtn{1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CntMax    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);

    logic [NumBits-1:0] raw;
    logic [NumBits-1:0] sync1_q;
    logic [NumBits-1:0] sync2_q;
    logic [NumBits-1:0] stable_q;
    logic [NumBits-1:0] stable_d;

    logic [CNT_WIDTH-1:0] cnt_q [NumBits];
    logic [CNT_WIDTH-1:0] cnt_d [NumBits];

    logic [NumBtn-1:0] press_q;
    logic [NumBtn-1:0] press_d;
    logic [NumBtn-1:0] latch_q;
    logic [NumBtn-1:0] latch_d;
    logic              sw_chg_q;
    logic              sw_chg_d;

    assign raw = {switch_raw, button_raw};

    // Per-bit debounce: any agreement with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NumBits; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    // Event outputs are derived from the accepted-level transition on this edge.
    always_comb begin
        press_d  = stable_q[NumBtn-1:0] & ~stable_d[NumBtn-1:0];
        latch_d  = press_d | (latch_q & ~clear_press);
        sw_chg_d = |(stable_q[NumBits-1:NumBtn] ^ stable_d[NumBits-1:NumBtn]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q  <= IdleLevel;
            sync2_q  <= IdleLevel;
            stable_q <= IdleLevel;
            press_q  <= '0;
            latch_q  <= '0;
            sw_chg_q <= 1'b0;
            for (int i = 0; i < NumBits; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            latch_q  <= latch_d;
            sw_chg_q <= sw_chg_d;
            for (int i = 0; i < NumBits; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign button         = stable_q[NumBtn-1:0];
    assign switch         = stable_q[NumBits-1:NumBtn];
    assign button_press   = press_q;
    assign press_latch    = latch_q;
    assign switch_changed = sw_chg_q;

endmodule
